// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_master_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUS  = ST_BUS,
        RESP = ST_RESP
    } state_t;

    localparam int SEL_W = 4;

    localparam logic [31:0] RD_ERR_DATA = 32'h0;

endpackage

// File: rtl/wb_cmd_timeout.sv
// Up-counter for the bus-cycle watchdog: cleared on command accept, counts
// stalled bus cycles, flags the cycle whose count reaches TIMEOUT.
module wb_cmd_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // count is about to become TIMEOUT: this stalled cycle is the last one
    assign tc = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command
// stream. Optional ack watchdog enabled by WB_CMD_MASTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a command, bus idle
// BUS   | cyc/stb asserted, waiting for ack (or timeout)
// RESP  | response offered, waiting for rsp_ready_i
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [SEL_W-1:0] cmd_sel_i,
    input  logic [AW-1:0]    cmd_adr_i,
    input  logic [DW-1:0]    cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DW-1:0]    rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [AW-1:0]    wbm_adr_o,
    output logic [DW-1:0]    wbm_dat_o,
    input  logic [DW-1:0]    wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy_o
);

    state_t state, state_nxt;
    logic   cmd_take;
    logic   bus_done;
    logic   tmo_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic rsp_err;

    wb_cmd_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk  (wb_clk_i),
        .reset(wb_rst_i),
        .clr  (cmd_take),
        .en   ((state == BUS) && !wbm_ack_i),
        .tc   (tmo_hit)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rsp_err <= 1'b0;
        end else if (bus_done) begin
            rsp_err <= !wbm_ack_i;
        end
    end

    assign rsp_err_o = rsp_err;
`else
    logic timeout_unused;

    assign tmo_hit        = 1'b0;
    assign rsp_err_o      = 1'b0;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_take  = 1'b0;
        bus_done  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    cmd_take  = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i || tmo_hit) begin
                    bus_done  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat_o <= '0;
        end else begin
            if (cmd_take) begin
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
            end
            // writes and aborted transfers both report the zero data word
            if (bus_done) begin
                rsp_dat_o <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : DW'(RD_ERR_DATA);
            end
        end
    end

    assign cmd_ready_o = (state == IDLE);
    assign wbm_cyc_o   = (state == BUS);
    assign wbm_stb_o   = (state == BUS);
    assign rsp_valid_o = (state == RESP);
    assign busy_o      = (state != IDLE);

endmodule
